ov5642_pixel_packer: RTL and testbench

Packs the camera byte stream from the OV5642 parallel front end into 16-bit RGB565 pixels and re-emits them as an AXI4-Stream video stream with tready back-pressure. Inserts `tuser` for start of frame and `tlast` for end of line. Sits directly downstream of the OV5642 capture interface, in the same `pclk` domain, and feeds a VDMA or video-processing chain. The upstream stream cannot stall, so a small FIFO absorbs downstream back-pressure and overflow is flagged.

---
 rtl/ov5642_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/ov5642_pixel_packer.sv | 149 ++++++++++++++
 tb/tb_ov5642_pixel_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ov5642_pkg.sv
// rtl/ov5642_pkg.sv - shared widths, FIFO entry layout and packer states
package ov5642_pkg;

  localparam int R_W       = 5;
  localparam int G_W       = 6;
  localparam int B_W       = 5;
  localparam int PIX_W     = R_W + G_W + B_W;
  localparam int TLAST_BIT = 16;
  localparam int TUSER_BIT = 17;
  localparam int ENTRY_W   = 18;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic user,
                                                    input logic last,
                                                    input logic [PIX_W-1:0] pix);
    return {user, last, pix};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with registered full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is still accepted when the head leaves on the same edge.
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign count_n = count + CW'(do_wr) - CW'(do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ov5642_pixel_packer.sv
// rtl/ov5642_pixel_packer.sv - camera bytes to RGB565 AXI4-Stream video with SOF/EOL markers
module ov5642_pixel_packer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        overflow,
  output logic        frame_err
);
  import ov5642_pkg::*;

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_t               state, state_n;
  logic [XW-1:0]        x, x_n;
  logic [YW-1:0]        y, y_n;
  logic                 ph, ph_n;
  logic [7:0]           hi, hi_n;
  logic                 pk_valid, pk_valid_n;
  logic [ENTRY_W-1:0]   pk_entry, pk_entry_n;
  logic                 ferr_n;
  logic                 last_pix;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_rd;
  logic [ENTRY_W-1:0]   fifo_dout;

  assign last_pix = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_SYNC;
      x         <= '0;
      y         <= '0;
      ph        <= 1'b0;
      hi        <= '0;
      pk_valid  <= 1'b0;
      pk_entry  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      ph        <= ph_n;
      hi        <= hi_n;
      pk_valid  <= pk_valid_n;
      pk_entry  <= pk_entry_n;
      frame_err <= ferr_n;
      if (pk_valid && fifo_full && !fifo_rd) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    ph_n       = ph;
    hi_n       = hi;
    pk_valid_n = 1'b0;
    pk_entry_n = pk_entry;
    ferr_n     = 1'b0;
    unique case (state)
      ST_SYNC: begin
        if (s_tvalid && s_tlast) begin
          state_n = ST_ACTIVE;
          x_n     = '0;
          y_n     = '0;
          ph_n    = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (s_tvalid) begin
          if (!ph) begin
            // An early frame end on a high byte abandons that half pixel.
            if (s_tlast) begin
              ferr_n = 1'b1;
              x_n    = '0;
              y_n    = '0;
            end else begin
              hi_n = s_tdata;
              ph_n = 1'b1;
            end
          end else begin
            ph_n       = 1'b0;
            pk_valid_n = 1'b1;
            pk_entry_n = make_entry((x == '0) && (y == '0), x == X_LAST, {hi, s_tdata});
            if (s_tlast || last_pix) begin
              x_n    = '0;
              y_n    = '0;
              ferr_n = s_tlast && !last_pix;
              if (last_pix && !s_tlast) state_n = ST_DRAIN;
            end else if (x == X_LAST) begin
              x_n = '0;
              y_n = y + 1'b1;
            end else begin
              x_n = x + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (s_tvalid && s_tlast) begin
          ferr_n  = 1'b1;
          state_n = ST_ACTIVE;
          x_n     = '0;
          y_n     = '0;
          ph_n    = 1'b0;
        end
      end
      default: state_n = ST_SYNC;
    endcase
  end

  assign fifo_rd = m_tvalid && m_tready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (rst),
    .wr_en   (pk_valid),
    .wr_data (pk_entry),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_dout[PIX_W-1:0];
  assign m_tuser  = fifo_dout[TUSER_BIT];
  assign m_tlast  = fifo_dout[TLAST_BIT];

endmodule

// File: tb/tb_ov5642_pixel_packer.sv
// tb/tb_ov5642_pixel_packer.sv - randomized bench for ov5642_pixel_packer against a frame-level model
module tb_ov5642_pixel_packer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tuser;
  logic        m_tlast;
  logic        overflow;
  logic        frame_err;

  ov5642_pixel_packer #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (D)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: mode 0=waiting for sync, 1=in frame, 2=frame done; p is the linear pixel index.
  logic [17:0] q[$];
  int          mode;
  int          p;
  bit          have_hi;
  logic [7:0]  hi_b;
  bit          pend;
  logic [17:0] pend_e;
  bit          exp_ovf;
  bit          exp_ferr;
  bit          full_b;
  bit          rd_b;

  always @(posedge pclk) begin
    if (rst) begin
      q.delete();
      mode = 0; p = 0; have_hi = 0; hi_b = '0;
      pend = 0; exp_ovf = 0; exp_ferr = 0;
    end else begin
      full_b = (q.size() == D);
      rd_b   = (q.size() > 0) && m_tready;
      if (rd_b) void'(q.pop_front());
      if (pend) begin
        if (!full_b || rd_b) q.push_back(pend_e);
        else exp_ovf = 1;
      end
      pend = 0;
      exp_ferr = 0;
      if (s_tvalid) begin
        if (mode == 0) begin
          if (s_tlast) begin mode = 1; p = 0; have_hi = 0; end
        end else if (mode == 1) begin
          if (!have_hi) begin
            if (s_tlast) begin exp_ferr = 1; p = 0; end
            else begin hi_b = s_tdata; have_hi = 1; end
          end else begin
            have_hi = 0;
            pend = 1;
            pend_e = {p == 0, (p % H) == H - 1, hi_b, s_tdata};
            if (p == H * V - 1) begin
              if (!s_tlast) mode = 2;
              p = 0;
            end else if (s_tlast) begin
              exp_ferr = 1;
              p = 0;
            end else begin
              p++;
            end
          end
        end else begin
          if (s_tlast) begin exp_ferr = 1; mode = 1; p = 0; have_hi = 0; end
        end
      end
    end
  end

  int          ferr_seen = 0;
  int          valid_seen = 0;
  logic [17:0] head;

  always @(negedge pclk) begin
    check("m_tvalid", m_tvalid, q.size() > 0);
    if (q.size() > 0) begin
      head = q[0];
      check("m_tdata", m_tdata, head[15:0]);
      check("m_tuser", m_tuser, head[17]);
      check("m_tlast", m_tlast, head[16]);
    end
    check("overflow", overflow, exp_ovf);
    check("frame_err", frame_err, exp_ferr);
    if (frame_err === 1'b1) ferr_seen++;
    if (m_tvalid === 1'b1) valid_seen++;
  end

  int ready_mode = 0;

  task automatic drive_cycle(input bit v, input logic [7:0] b, input bit l);
    @(negedge pclk);
    #1;
    s_tvalid = v;
    s_tdata  = b;
    s_tlast  = l;
    if (ready_mode == 0) m_tready = 1'b1;
    else if (ready_mode == 1) m_tready = 1'b0;
    else m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(0, 8'h00, 0);
  endtask

  task automatic send_frame(input int nbytes, input bit last_at_end, input int gap_pct);
    for (int i = 0; i < nbytes; i++) begin
      drive_cycle(1, 8'($urandom), last_at_end && (i == nbytes - 1));
      while (int'($urandom_range(0, 99)) < gap_pct) drive_cycle(0, 8'h00, 0);
    end
  endtask

  int f0;
  int v0;

  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    v0 = valid_seen;
    send_frame(16, 1, 0);
    idle(3);
    check("sync_discard_valid", valid_seen - v0, 0);

    f0 = ferr_seen;
    send_frame(16, 1, 0);
    idle(4);
    check("normal_ferr_count", ferr_seen - f0, 0);

    f0 = ferr_seen;
    send_frame(9, 1, 0);
    idle(2);
    check("short_ferr_count", ferr_seen - f0, 1);
    send_frame(16, 1, 0);
    idle(4);

    f0 = ferr_seen;
    send_frame(20, 1, 0);
    idle(4);
    check("long_ferr_count", ferr_seen - f0, 1);

    ready_mode = 1;
    send_frame(16, 1, 0);
    idle(4);
    check("stall_overflow_sticky", overflow, 1);
    ready_mode = 0;
    idle(8);

    ready_mode = 1;
    send_frame(6, 0, 0);
    idle(2);
    @(negedge pclk);
    #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    @(negedge pclk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    v0 = valid_seen;
    send_frame(16, 1, 0);
    idle(3);
    check("post_reset_discard_valid", valid_seen - v0, 0);
    send_frame(16, 1, 0);
    idle(4);

    for (int k = 0; k < 40; k++) begin
      ready_mode = (k % 3 == 0) ? 0 : 2;
      send_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : 16, 1, 20);
      idle(int'($urandom_range(0, 4)));
    end
    ready_mode = 0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
